// File: rtl/pe_channel_accumulator_pkg.sv
// pe_channel_accumulator_pkg: shared widths, slice helper and FSM encoding for the PE output accumulator
package pe_channel_accumulator_pkg;
    typedef enum logic {FIRST = 1'b0, ACC = 1'b1} state_e;
    // Partial-sum width of one PE element: data x kernel product grown by the MAC count.
    function automatic int elem_w(int data_w, int kern_w, int macs);
        return data_w + kern_w + $clog2(macs);
    endfunction
    // LSB of slot idx in a flat vector of w-bit slots (lanes or elements).
    function automatic int slice_lsb(int idx, int w);
        return idx * w;
    endfunction
    localparam int DEF_OUT_TILE = 2;
    localparam int DEF_ELEM_W = elem_w(16, 8, 32);
    localparam int DEF_PN = 2;
    localparam int DEF_PASSES = 4;
    localparam int DEF_RELU = 1;
endpackage

// File: rtl/pe_channel_accumulator_if.sv
// pe_channel_accumulator_if: input partial-sum stream, output tile stream and clear
//   master: clear, in_valid, in_data, out_ready out; in_ready, out_valid, out_data in
//   slave:  the accumulator side, directions mirrored
interface pe_channel_accumulator_if #(
    parameter int OUT_TILE = 2,
    parameter int ELEM_W = 29,
    parameter int SUM_W = 31,
    parameter int Pn = 2
);
    localparam int TE = OUT_TILE * OUT_TILE;
    logic clear;
    logic in_valid;
    logic in_ready;
    logic [TE*ELEM_W*Pn-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [TE*SUM_W*Pn-1:0] out_data;
    modport master(output clear, in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave(input clear, in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/pe_lane_acc.sv
// pe_lane_acc: one lane's OUT_TILE^2 signed accumulators with registered, optionally ReLU'd output
//   clk, reset (async active-low), acc_en (beat accepted), first (start of tile),
//   last (final pass), in_lane (TE x ELEM_W), out_lane (TE x SUM_W, held until next final beat)
module pe_lane_acc import pe_channel_accumulator_pkg::*; #(
    parameter int TE = 4,
    parameter int ELEM_W = 29,
    parameter int SUM_W = 31,
    parameter int RELU = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  acc_en,
    input  logic                  first,
    input  logic                  last,
    input  logic [TE*ELEM_W-1:0]  in_lane,
    output logic [TE*SUM_W-1:0]   out_lane
);
    for (genvar e = 0; e < TE; e++) begin : g_elem
        logic signed [SUM_W-1:0] acc_q;
        logic signed [SUM_W-1:0] out_q;
        logic signed [SUM_W-1:0] sum;
        // A tile's first beat overwrites the accumulator, so stale partials never leak in.
        assign sum = (first ? '0 : acc_q) + SUM_W'($signed(in_lane[slice_lsb(e, ELEM_W) +: ELEM_W]));
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc_q <= '0;
                out_q <= '0;
            end else begin
                if (acc_en) acc_q <= sum;
                if (acc_en && last) out_q <= (RELU != 0 && sum[SUM_W-1]) ? '0 : sum;
            end
        end
        assign out_lane[slice_lsb(e, SUM_W) +: SUM_W] = out_q;
    end
endmodule

// File: rtl/pe_channel_accumulator.sv
// pe_channel_accumulator: accumulates PE partial sums over PASSES beats and streams finished tiles
//   clk, reset (async active-low), bus (slave: clear, in stream, out stream),
//   tile_count (tiles handed off, wraps at 2^16)
module pe_channel_accumulator import pe_channel_accumulator_pkg::*; #(
    parameter int OUT_TILE = DEF_OUT_TILE,
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int Pn = DEF_PN,
    parameter int PASSES = DEF_PASSES,
    parameter int RELU = DEF_RELU
) (
    input  logic                          clk,
    input  logic                          reset,
    pe_channel_accumulator_if.slave       bus,
    output logic [15:0]                   tile_count
);
    localparam int SUM_W = ELEM_W + $clog2(PASSES);
    localparam int TE = OUT_TILE * OUT_TILE;
    localparam int CW = PASSES > 1 ? $clog2(PASSES) : 1;
    state_e state_q, state_d;
    logic [CW-1:0] pass_cnt_q, pass_cnt_d;
    logic out_valid_q, out_valid_d;
    logic [15:0] tile_count_q, tile_count_d;
    logic accept, last, first, restart;
    // A stalled output blocks every pass, not just the final one, so no beat is ever dropped.
    assign bus.in_ready = reset && !bus.clear && (!out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;
    assign last = pass_cnt_q == CW'(PASSES - 1);
    assign restart = bus.clear || (accept && last);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FIRST;
            pass_cnt_q <= '0;
            out_valid_q <= 1'b0;
            tile_count_q <= '0;
        end else begin
            state_q <= state_d;
            pass_cnt_q <= pass_cnt_d;
            out_valid_q <= out_valid_d;
            tile_count_q <= tile_count_d;
        end
    end
    always_comb begin
        state_d = restart ? FIRST : accept ? ACC : state_q;
        pass_cnt_d = restart ? '0 : accept ? pass_cnt_q + 1'b1 : pass_cnt_q;
    end
    // A new final beat in the same cycle as a handoff keeps out_valid high with fresh data.
    always_comb begin
        first = state_q == FIRST;
        out_valid_d = (accept && last) ? 1'b1 : bus.out_ready ? 1'b0 : out_valid_q;
        tile_count_d = tile_count_q + 16'(out_valid_q && bus.out_ready);
    end
    for (genvar l = 0; l < Pn; l++) begin : g_lane
        pe_lane_acc #(.TE(TE), .ELEM_W(ELEM_W), .SUM_W(SUM_W), .RELU(RELU)) u_lane (
            .clk(clk),
            .reset(reset),
            .acc_en(accept),
            .first(first),
            .last(last),
            .in_lane(bus.in_data[slice_lsb(l, TE*ELEM_W) +: TE*ELEM_W]),
            .out_lane(bus.out_data[slice_lsb(l, TE*SUM_W) +: TE*SUM_W])
        );
    end
    assign bus.out_valid = out_valid_q;
    assign tile_count = tile_count_q;
endmodule

// File: tb/tb_pe_channel_accumulator.sv
// tb_pe_channel_accumulator: scoreboard bench for ReLU / no-ReLU PASSES=4 instances and a PASSES=1 instance
module tb_pe_channel_accumulator;
    localparam int EW = 29;
    localparam int PS = 4;
    localparam int SW = 31;
    localparam int SWC = 29;
    localparam int NE = 8;
    localparam int IW = NE * EW;
    localparam int OW = NE * SW;
    localparam int OWC = NE * SWC;
    localparam int MAXP = 268435455;
    localparam int MINN = -268435456;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] tc_a, tc_b, tc_c;
    int tests = 0;
    int fails = 0;
    logic [OW-1:0] qa[$];
    logic [OW-1:0] qb[$];
    logic [OWC-1:0] qc[$];
    logic signed [SW-1:0] acc_m[NE];
    int cnt_m = 0;

    always #5 clk = ~clk;

    pe_channel_accumulator_if #(.OUT_TILE(2), .ELEM_W(EW), .SUM_W(SW), .Pn(2)) ia();
    pe_channel_accumulator_if #(.OUT_TILE(2), .ELEM_W(EW), .SUM_W(SW), .Pn(2)) ib();
    pe_channel_accumulator_if #(.OUT_TILE(2), .ELEM_W(EW), .SUM_W(SWC), .Pn(2)) ic();

    assign ib.clear = ia.clear;
    assign ib.in_valid = ia.in_valid;
    assign ib.in_data = ia.in_data;
    assign ib.out_ready = ia.out_ready;

    pe_channel_accumulator #(.OUT_TILE(2), .ELEM_W(EW), .Pn(2), .PASSES(4), .RELU(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ia), .tile_count(tc_a));
    pe_channel_accumulator #(.OUT_TILE(2), .ELEM_W(EW), .Pn(2), .PASSES(4), .RELU(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ib), .tile_count(tc_b));
    pe_channel_accumulator #(.OUT_TILE(2), .ELEM_W(EW), .Pn(2), .PASSES(1), .RELU(1)) dut_c (
        .clk(clk), .reset(reset), .bus(ic), .tile_count(tc_c));

    always @(negedge clk) begin
        if (ia.out_valid && ia.out_ready) begin
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL sb_a unexpected output %h, required none", ia.out_data);
            end else begin
                logic [OW-1:0] x;
                x = qa.pop_front();
                if (ia.out_data !== x) begin
                    fails++;
                    $display("FAIL sb_a got %h required %h", ia.out_data, x);
                end
            end
        end
        if (ib.out_valid && ib.out_ready) begin
            tests++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL sb_b unexpected output %h, required none", ib.out_data);
            end else begin
                logic [OW-1:0] x;
                x = qb.pop_front();
                if (ib.out_data !== x) begin
                    fails++;
                    $display("FAIL sb_b got %h required %h", ib.out_data, x);
                end
            end
        end
        if (ic.out_valid && ic.out_ready) begin
            tests++;
            if (qc.size() == 0) begin
                fails++;
                $display("FAIL sb_c unexpected output %h, required none", ic.out_data);
            end else begin
                logic [OWC-1:0] x;
                x = qc.pop_front();
                if (ic.out_data !== x) begin
                    fails++;
                    $display("FAIL sb_c got %h required %h", ic.out_data, x);
                end
            end
        end
    end

    function automatic logic [IW-1:0] mk(input int a, input int b, input int c, input int d, input int l1);
        logic [IW-1:0] r;
        r[0*EW +: EW] = EW'(a);
        r[1*EW +: EW] = EW'(b);
        r[2*EW +: EW] = EW'(c);
        r[3*EW +: EW] = EW'(d);
        for (int k = 4; k < NE; k++) r[k*EW +: EW] = EW'(l1);
        return r;
    endfunction

    function automatic logic [IW-1:0] fill(input int v);
        return mk(v, v, v, v, v);
    endfunction

    task automatic model_reset();
        cnt_m = 0;
        for (int k = 0; k < NE; k++) acc_m[k] = '0;
    endtask

    task automatic model_accept(input logic [IW-1:0] d);
        logic signed [EW-1:0] e;
        logic [OW-1:0] xa, xb;
        for (int k = 0; k < NE; k++) begin
            e = d[k*EW +: EW];
            acc_m[k] = acc_m[k] + e;
        end
        cnt_m++;
        if (cnt_m == PS) begin
            for (int k = 0; k < NE; k++) begin
                xb[k*SW +: SW] = acc_m[k];
                xa[k*SW +: SW] = acc_m[k] < 0 ? '0 : acc_m[k];
            end
            qa.push_back(xa);
            qb.push_back(xb);
            model_reset();
        end
    endtask

    task automatic beat(input logic [IW-1:0] d);
        bit done;
        done = 0;
        ia.in_valid = 1'b1;
        ia.in_data = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ia.in_ready) begin
                model_accept(d);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout in_ready stayed %b, required 1", ia.in_ready);
        end
    endtask

    task automatic idle(input int n);
        ia.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests += 4;
        if (ia.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b required 0", ia.in_ready); end
        if (ia.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b required 0", ia.out_valid); end
        if (ia.out_data !== '0) begin fails++; $display("FAIL rst_out_data got %h required 0", ia.out_data); end
        if (tc_a !== 16'd0) begin fails++; $display("FAIL rst_tile_count got %0d required 0", tc_a); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (ia.in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got %b required 1", ia.in_ready); end
        model_reset();
    endtask

    task automatic test_basic();
        logic signed [SW-1:0] t;
        ia.out_ready = 1'b1;
        repeat (4) beat(mk(1, 2, 3, 4, -5));
        ia.in_valid = 1'b0;
        @(negedge clk);
        tests += 3;
        if (ia.out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got %b required 1", ia.out_valid); end
        t = ia.out_data[3*SW +: SW];
        if (t !== 16) begin fails++; $display("FAIL basic_lane0_e3 got %0d required 16", t); end
        t = ib.out_data[4*SW +: SW];
        if (t !== -20) begin fails++; $display("FAIL basic_norelu_lane1 got %0d required -20", t); end
        @(posedge clk);
        #1;
        tests += 2;
        if (ia.out_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse got %b required 0", ia.out_valid); end
        if (tc_a !== 16'd1) begin fails++; $display("FAIL basic_tile_count got %0d required 1", tc_a); end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] snap;
        logic signed [SW-1:0] t;
        logic [15:0] tc0;
        tc0 = tc_a;
        ia.out_ready = 1'b0;
        repeat (4) beat(mk(10, 20, 30, 40, -1));
        ia.in_valid = 1'b1;
        ia.in_data = fill(1);
        snap = ia.out_data;
        t = snap[0 +: SW];
        tests++;
        if (t !== 40) begin fails++; $display("FAIL bp_held_value got %0d required 40", t); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests += 2;
            if (ia.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cycle %0d got %b required 0", i, ia.in_ready); end
            if (ia.out_data !== snap) begin fails++; $display("FAIL bp_stable cycle %0d got %h required %h", i, ia.out_data, snap); end
            @(posedge clk);
            #1;
        end
        ia.out_ready = 1'b1;
        #1;
        tests += 2;
        if (ia.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b required 1", ia.in_ready); end
        if (tc_a !== tc0) begin fails++; $display("FAIL bp_tc_before got %0d required %0d", tc_a, tc0); end
        beat(fill(1));
        tests++;
        if (tc_a !== tc0 + 16'd1) begin fails++; $display("FAIL bp_tc_after got %0d required %0d", tc_a, tc0 + 16'd1); end
        repeat (3) beat(fill(1));
        idle(2);
    endtask

    task automatic test_extremes();
        logic signed [SW-1:0] t;
        ia.out_ready = 1'b1;
        repeat (4) beat(fill(MAXP));
        t = ia.out_data[0 +: SW];
        tests++;
        if (t !== 31'sd1073741820) begin fails++; $display("FAIL ext_max got %0d required 1073741820", t); end
        repeat (4) beat(fill(MINN));
        tests += 2;
        t = ib.out_data[7*SW +: SW];
        if (t !== -31'sd1073741824) begin fails++; $display("FAIL ext_min got %0d required -1073741824", t); end
        t = ia.out_data[7*SW +: SW];
        if (t !== 0) begin fails++; $display("FAIL ext_min_relu got %0d required 0", t); end
        idle(2);
    endtask

    task automatic test_clear();
        logic signed [SW-1:0] t;
        repeat (2) beat(fill(100));
        ia.clear = 1'b1;
        ia.in_valid = 1'b1;
        ia.in_data = fill(999);
        @(negedge clk);
        tests++;
        if (ia.in_ready !== 1'b0) begin fails++; $display("FAIL clear_in_ready got %b required 0", ia.in_ready); end
        @(posedge clk);
        #1;
        ia.clear = 1'b0;
        model_reset();
        repeat (4) beat(fill(7));
        t = ia.out_data[0 +: SW];
        tests++;
        if (t !== 28) begin fails++; $display("FAIL clear_result got %0d required 28", t); end
        idle(2);
    endtask

    task automatic test_async_reset();
        repeat (2) beat(fill(3));
        #2;
        ia.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests += 4;
        if (ia.out_valid !== 1'b0) begin fails++; $display("FAIL ar_tile_out_valid got %b required 0", ia.out_valid); end
        if (ia.in_ready !== 1'b0) begin fails++; $display("FAIL ar_tile_in_ready got %b required 0", ia.in_ready); end
        if (ia.out_data !== '0) begin fails++; $display("FAIL ar_tile_out_data got %h required 0", ia.out_data); end
        if (tc_a !== 16'd0) begin fails++; $display("FAIL ar_tile_count got %0d required 0", tc_a); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        ia.out_ready = 1'b0;
        repeat (4) beat(fill(5));
        #2;
        ia.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests += 2;
        if (ia.out_valid !== 1'b0) begin fails++; $display("FAIL ar_stall_out_valid got %b required 0", ia.out_valid); end
        if (ib.out_data !== '0) begin fails++; $display("FAIL ar_stall_out_data got %h required 0", ib.out_data); end
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        ia.out_ready = 1'b1;
        repeat (4) beat(fill(-2));
        idle(2);
        tests++;
        if (tc_a !== 16'd1) begin fails++; $display("FAIL ar_after_tile_count got %0d required 1", tc_a); end
    endtask

    task automatic test_passes1();
        int vals[5];
        logic [IW-1:0] d;
        logic [OWC-1:0] x;
        int el;
        vals = '{5, -3, 0, 100, -1};
        ic.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < NE; k++) begin
                el = vals[i] + k - 4;
                d[k*EW +: EW] = EW'(el);
                x[k*SWC +: SWC] = el < 0 ? '0 : SWC'(el);
            end
            ic.in_valid = 1'b1;
            ic.in_data = d;
            @(negedge clk);
            tests++;
            if (ic.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL p1_in_ready beat %0d got %b required 1", i, ic.in_ready);
            end else begin
                qc.push_back(x);
            end
            @(posedge clk);
            #1;
            tests++;
            if (tc_c !== 16'(i)) begin fails++; $display("FAIL p1_tile_count beat %0d got %0d required %0d", i, tc_c, i); end
        end
        ic.in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (tc_c !== 16'd5) begin fails++; $display("FAIL p1_final_count got %0d required 5", tc_c); end
    endtask

    initial begin
        ia.clear = 1'b0;
        ia.in_valid = 1'b0;
        ia.in_data = '0;
        ia.out_ready = 1'b1;
        ic.clear = 1'b0;
        ic.in_valid = 1'b0;
        ic.in_data = '0;
        ic.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_extremes();
        test_clear();
        test_async_reset();
        test_passes1();
        idle(3);
        tests++;
        if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
            fails++;
            $display("FAIL sb_drain pending a=%0d b=%0d c=%0d required 0", qa.size(), qb.size(), qc.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pe_channel_accumulator.md
# pe_channel_accumulator

Output-side stage that consumes the per-output-channel partial sums produced by the parallel PE array (Pn lanes, each a 2×2 output tile) and accumulates them across the PASSES input-channel groups needed to cover all input channels (CHANNELS / Pm). After the last pass it applies an optional ReLU and presents the finished output tile on a valid/ready stream to the output writer. It replaces the free-running valid of the PE array with a proper handshake, including backpressure.

## Interface
- OUT_TILE, 2: output tile edge; each lane carries OUT_TILE² elements.
- ELEM_W, 29: signed width of one incoming partial-sum element.
- Pn, 2: parallel output channels (lanes).
- PASSES, 4: input-channel groups per output tile; must be at least 1.
- RELU, 1: 1 clamps negative final sums to 0; 0 passes them through unchanged.
- SUM_W, ELEM_W + $clog2(PASSES) (derived, localparam): signed accumulator and output element width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; discards the in-progress partial tile.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the block can accept in_data this cycle.
- in_data  in  OUT_TILE²·ELEM_W·Pn  lane i occupies bits [i·OUT_TILE²·ELEM_W +: OUT_TILE²·ELEM_W]; element e of a lane sits at [e·ELEM_W +: ELEM_W].
- out_valid  out  1  out_data holds a finished tile.
- out_ready  in  1  the consumer accepts out_data.
- out_data  out  OUT_TILE²·SUM_W·Pn  same packing as in_data, using SUM_W per element.
- tile_count  out  16  number of tiles handed off; wraps modulo 2^16.

## Operation
- A beat is accepted when in_valid && in_ready.
- in_ready = !clear && (!out_valid || out_ready).
- pass_cnt (0..PASSES-1) counts accepted beats within the current tile.
- Two states: FIRST (pass_cnt = 0) and ACC (pass_cnt > 0).
- Accepted beat in FIRST: acc ← sign-extend(in). acc is Pn·OUT_TILE² independent signed SUM_W accumulators.
- Accepted beat in ACC: acc ← acc + sign-extend(in).
- Final beat (pass_cnt = PASSES-1):
  - each element of sum = acc + in (or just in when PASSES = 1) is written to out_data, with ReLU applied when RELU = 1;
  - out_valid ← 1, pass_cnt ← 0, state ← FIRST.
- Otherwise: pass_cnt ← pass_cnt + 1, state ← ACC.
- Output handshake: out_valid && out_ready clears out_valid and increments tile_count, unless a new final beat loads in the same cycle, in which case out_valid stays 1 with the new data.
- out_data is held stable while out_valid && !out_ready.
- clear: pass_cnt ← 0, state ← FIRST, and no beat is accepted that cycle. The out register and tile_count are unaffected, and a pending output handshake still completes.
- Widths: SUM_W guarantees no overflow, so there is no saturation. Arithmetic is two's complement per element, and no element carries into a neighbour.

## Timing
- Reset values: in_ready 0 while reset is asserted, then 1 from the first cycle after release. out_valid 0, out_data 0, tile_count 0, pass_cnt 0, state FIRST, acc 0.
- Latency: final beat accepted at edge N gives out_valid = 1 with data visible after edge N.
- Throughput: one beat per cycle with out_ready held high, i.e. one tile every PASSES cycles.
- Backpressure: while out_valid && !out_ready, in_ready = 0 for every pass, not only the final one. Accumulation therefore stalls; it does not drop beats.
- Reset asserted mid-tile: all state returns to reset values immediately (asynchronous) and the partial tile is lost.

## Structure
- Shared package for the array: width helpers (ELEM_W formula from the kernel and input widths), the lane/element slice function, and the FIRST/ACC state encoding.
- One sub-module, pe_lane_acc: one lane's OUT_TILE² accumulators plus ReLU, instantiated Pn times. Control (pass_cnt, state, handshake, tile_count) lives in the top level.

## Test plan
- PASSES = 4, out_ready = 1; lane 0 elements = 1, 2, 3, 4 and lane 1 elements = -5 on every pass; 4 beats on consecutive cycles → one out_valid pulse the cycle after beat 4. Lane 0 = 4, 8, 12, 16. Lane 1 = 0 with RELU = 1, or -20 with RELU = 0. tile_count = 1.
- Backpressure: out_ready = 0 after the first tile completes → in_ready = 0, out_data stable for 10 cycles. Then out_ready = 1 → tile_count increments and in_ready returns to 1 in the same cycle.
- Extremes: all elements at max positive (2^28 - 1) for 4 passes → 4·(2^28 - 1) exactly. All at min (-2^28) with RELU = 0 → -2^30 exactly, with no carry into adjacent elements.
- Clear after 2 of 4 beats, then 4 fresh beats of value 7 → output element = 28. The stale partials do not leak into the result.
- Async reset asserted mid-tile and mid-stall → all outputs 0 immediately. After release, a full tile produces the correct result with tile_count = 1.
- PASSES = 1 with back-to-back beats and out_ready = 1 → one output per cycle equal to relu(in), and tile_count increments every cycle.
